// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage of the 5-stage RV32I pipeline.
//
// Generates sequential PCs, issues pipelined requests to an in-order,
// variable-latency instruction memory, buffers returned instructions in a
// small FIFO and presents the FIFO head to decode (IF/ID register inputs).
// Redirects from execute flush the buffer and discard wrong-path responses
// that are still in flight.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   DEPTH     fetch-buffer entries and maximum outstanding requests
//             (power of two, >= 2)
//
// Optional feature (macro FETCH_BYPASS_EN):
//   defined   -> a response arriving while the buffer is empty (and no drops
//                are pending) is shown on the outputs in the same cycle
//   undefined -> outputs always come from the buffer registers
//
// Ports:
//   clk          clock, all state changes on posedge
//   rst_n        synchronous active-low reset
//   Stall        hazard-unit hold; head entry is not consumed
//   PCSrcE       redirect request from execute (priority over Stall)
//   PCTargetE    redirect target (low two bits ignored)
//   imem_req     request valid
//   imem_addr    request word address
//   imem_ready   memory accepts the request this cycle
//   imem_rvalid  response valid (in order, >= 1 cycle after acceptance)
//   imem_rdata   response instruction
//   InstrF       head instruction, NOP when ValidF=0
//   PCF          head PC, 0 when ValidF=0
//   inc_PCF      PCF+4, 0 when ValidF=0
//   ValidF       head entry valid
//
// Handshakes: a request transfers on a cycle where imem_req && imem_ready;
// a response transfers on any cycle with imem_rvalid (no back-pressure).
// The head entry is consumed on a cycle where ValidF && !Stall && !PCSrcE.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] inc_PCF,
  output logic        ValidF
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  // Fetch buffer (decoded-side FIFO) and pending-PC queue (one entry per
  // outstanding request, popped in response order).
  logic [31:0]   r_buf_pc    [DEPTH];
  logic [31:0]   r_buf_instr [DEPTH];
  logic [31:0]   r_pend_pc   [DEPTH];
  logic [AW-1:0] r_buf_rd;
  logic [AW-1:0] r_buf_wr;
  logic [AW-1:0] r_pend_rd;
  logic [AW-1:0] r_pend_wr;
  logic [CW-1:0] r_buf_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop_cnt;
  logic [31:0]   r_fetch_pc;

  logic [CW:0]   w_credit;
  logic          w_req;
  logic          w_accept;
  logic          w_buf_empty;
  logic          w_drop_now;
  logic          w_resp_keep;
  logic          w_bypass;
  logic          w_valid;
  logic          w_pop;
  logic          w_buf_pop;
  logic          w_push;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_head_instr;
  logic [31:0]   w_target;

  // Credit rule: outstanding requests plus buffered entries never exceed
  // DEPTH, so every response (kept or dropped) always has a buffer slot.
  assign w_credit    = {1'b0, r_inflight} + {1'b0, r_buf_count};
  assign w_req       = rst_n && !PCSrcE && (w_credit < L_DEPTH);
  assign w_accept    = w_req && imem_ready;
  assign w_buf_empty = (r_buf_count == '0);
  assign w_drop_now  = imem_rvalid && (r_drop_cnt != '0);
  // A response landing in the redirect cycle is wrong-path as well.
  assign w_resp_keep = imem_rvalid && (r_drop_cnt == '0) && !PCSrcE;
  assign w_target    = PCTargetE & 32'hFFFF_FFFC;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_buf_empty && (r_drop_cnt == '0) && imem_rvalid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_valid   = !w_buf_empty || w_bypass;
  assign w_pop     = w_valid && !Stall && !PCSrcE;
  assign w_buf_pop = w_pop && !w_buf_empty;
  // A bypassed response that decode takes this cycle never enters the FIFO.
  assign w_push    = w_resp_keep && !(w_bypass && w_pop);

  always_comb begin
    w_head_pc    = '0;
    w_head_instr = NOP;
    if (!w_buf_empty) begin
      w_head_pc    = r_buf_pc[r_buf_rd];
      w_head_instr = r_buf_instr[r_buf_rd];
    end else if (w_bypass) begin
      w_head_pc    = r_pend_pc[r_pend_rd];
      w_head_instr = imem_rdata;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;
  assign ValidF    = w_valid;
  assign InstrF    = w_head_instr;
  assign PCF       = w_head_pc;
  assign inc_PCF   = w_valid ? (w_head_pc + 32'd4) : 32'd0;

  // Control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc  <= RESET_PC;
      r_buf_rd    <= '0;
      r_buf_wr    <= '0;
      r_buf_count <= '0;
      r_pend_rd   <= '0;
      r_pend_wr   <= '0;
      r_inflight  <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_pend_wr  <= r_pend_wr + AW'(1);
      end
      if (imem_rvalid) begin
        r_pend_rd <= r_pend_rd + AW'(1);
      end
      if (w_accept && !imem_rvalid) begin
        r_inflight <= r_inflight + CW'(1);
      end else if (!w_accept && imem_rvalid) begin
        r_inflight <= r_inflight - CW'(1);
      end

      if (PCSrcE) begin
        // Every request still outstanding after this cycle is wrong-path.
        r_fetch_pc  <= w_target;
        r_buf_rd    <= '0;
        r_buf_wr    <= '0;
        r_buf_count <= '0;
        r_drop_cnt  <= r_inflight - CW'(imem_rvalid);
      end else begin
        if (w_push) begin
          r_buf_wr <= r_buf_wr + AW'(1);
        end
        if (w_buf_pop) begin
          r_buf_rd <= r_buf_rd + AW'(1);
        end
        r_buf_count <= r_buf_count + CW'(w_push) - CW'(w_buf_pop);
        if (w_drop_now) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
      end
    end
  end

  // Storage arrays need no reset; pointers/counters qualify their contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_buf_wr]    <= r_pend_pc[r_pend_rd];
      r_buf_instr[r_buf_wr] <= imem_rdata;
    end
    if (w_accept) begin
      r_pend_pc[r_pend_wr] <= r_fetch_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset / DUT
  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] inc_PCF;
  logic        ValidF;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .InstrF(InstrF), .PCF(PCF),
    .inc_PCF(inc_PCF), .ValidF(ValidF)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;

  // Model state: expected buffered PCs, outstanding requests {stale, pc},
  // memory queue {due_cycle, addr}.
  logic [31:0] exp_q[$];
  logic [32:0] pend_q[$];
  logic [63:0] mem_q[$];
  logic [31:0] m_fetch_pc;
  bit          m_live = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: in-order responses, each no earlier than mem_lat cycles after
  // acceptance; data is a fixed function of the address.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (mem_q.size() > 0 && mem_q[0][63:32] <= 32'(cyc)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mem_q[0][31:0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // Scoreboard: check outputs against the model, then advance the model.
  always @(negedge clk) begin : compare
    logic [31:0] hpc;
    logic [32:0] r;
    bit hv, byp, cons, exp_req;
    if (!rst_n) begin
      chk("req_in_reset", {31'b0, imem_req}, 32'd0);
      m_fetch_pc = RESET_PC;
      exp_q.delete();
      pend_q.delete();
      mem_q.delete();
      m_live = 1'b1;
    end else if (m_live) begin
      byp = BYP && exp_q.size() == 0 && imem_rvalid && pend_q.size() > 0 && !pend_q[0][32];
      hv  = exp_q.size() > 0 || byp;
      hpc = (exp_q.size() > 0) ? exp_q[0] : (byp ? pend_q[0][31:0] : 32'd0);
      chk("ValidF",  {31'b0, ValidF}, {31'b0, hv});
      chk("PCF",     PCF,     hv ? hpc : 32'd0);
      chk("inc_PCF", inc_PCF, hv ? hpc + 32'd4 : 32'd0);
      chk("InstrF",  InstrF,  hv ? instr_of(hpc) : NOP);
      exp_req = !PCSrcE && (pend_q.size() + exp_q.size() < DEPTH);
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_fetch_pc);

      cons = hv && !Stall && !PCSrcE;
      if (cons && exp_q.size() > 0) void'(exp_q.pop_front());
      if (imem_rvalid) begin
        if (pend_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_order: got response with no outstanding request (t=%0t)", $time);
        end else begin
          r = pend_q.pop_front();
          if (!r[32] && !PCSrcE && !(byp && cons)) exp_q.push_back(r[31:0]);
        end
      end
      chk("buf_bound", {31'b0, exp_q.size() <= DEPTH}, 32'd1);
      if (PCSrcE) begin
        exp_q.delete();
        foreach (pend_q[i]) pend_q[i][32] = 1'b1;
        m_fetch_pc = PCTargetE & 32'hFFFF_FFFC;
      end else if (exp_req && imem_ready) begin
        pend_q.push_back({1'b0, m_fetch_pc});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end

      if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (imem_req && imem_ready) mem_q.push_back({32'(cyc + mem_lat), imem_addr});
    end
  end

  // Directed stimulus with hand-computed literal expectations.
  initial begin : driver
    bit found, seen, seen_wrap, seen0;
    rst_n = 1'b0; Stall = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; imem_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset release and first fetches (1-cycle memory)
    @(negedge clk);
    chk("t1_req0",  {31'b0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'hBFC0_0000);
    chk("t1_valid0", {31'b0, ValidF}, 32'd0);
    chk("t1_instr0", InstrF, 32'h0000_0013);
    tick();
    @(negedge clk);
    chk("t1_addr1", imem_addr, 32'hBFC0_0004);
    tick();
    @(negedge clk);
`ifndef FETCH_BYPASS_EN
    chk("t1_valid2", {31'b0, ValidF}, 32'd1);
    chk("t1_pc2",    PCF,     32'hBFC0_0000);
    chk("t1_inc2",   inc_PCF, 32'hBFC0_0004);
    chk("t1_instr2", InstrF,  32'h1A65_0F0F);
`endif
    tick();
    Stall = 1'b1;
    @(negedge clk);
`ifndef FETCH_BYPASS_EN
    chk("t1_addr3", imem_addr, 32'hBFC0_0008);
`endif

    // Stall with a full buffer holds the head
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
`ifndef FETCH_BYPASS_EN
      chk("t2_hold_pc",    PCF,    32'hBFC0_0004);
      chk("t2_hold_instr", InstrF, 32'h1A65_0F0B);
      chk("t2_full_noreq", {31'b0, imem_req}, 32'd0);
`endif
      tick();
    end
    Stall = 1'b0;
    tick();
    @(negedge clk);
`ifndef FETCH_BYPASS_EN
    chk("t2_next_pc", PCF, 32'hBFC0_0008);
`endif
    tick();

    // Redirect together with Stall on a non-empty buffer
    Stall = 1'b1;
    repeat (4) tick();
    PCSrcE = 1'b1;
    PCTargetE = 32'hBFC0_0200;
    mem_lat = 3;
    @(negedge clk);
    chk("t4_nonempty", {31'b0, ValidF}, 32'd1);
    chk("t4_noreq",    {31'b0, imem_req}, 32'd0);
    tick();
    PCSrcE = 1'b0;
    Stall = 1'b0;
    @(negedge clk);
    chk("t4_flushed", {31'b0, ValidF}, 32'd0);

    // Two requests in flight, then redirect: both must be dropped
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && imem_ready && imem_addr == 32'hBFC0_0204) found = 1'b1;
      tick();
      if (!found) @(negedge clk);
    end
    chk("t3_two_inflight", {31'b0, found}, 32'd1);
    PCSrcE = 1'b1;
    PCTargetE = 32'hBFC0_0100;
    @(negedge clk);
    chk("t3_noreq", {31'b0, imem_req}, 32'd0);
    tick();
    PCSrcE = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (ValidF) begin
        seen = 1'b1;
        chk("t3_first_pc",  PCF,     32'hBFC0_0100);
        chk("t3_first_inc", inc_PCF, 32'hBFC0_0104);
      end
      tick();
    end
    chk("t3_target_seen", {31'b0, seen}, 32'd1);

    // Address wrap at the top of the address space (misaligned target)
    mem_lat = 1;
    PCSrcE = 1'b1;
    PCTargetE = 32'hFFFF_FFFB;
    tick();
    PCSrcE = 1'b0;
    seen_wrap = 1'b0;
    seen0 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ValidF && PCF == 32'hFFFF_FFFC) begin
        seen_wrap = 1'b1;
        chk("t5_inc_wrap",   inc_PCF, 32'h0000_0000);
        chk("t5_instr_wrap", InstrF,  32'h5A5A_F0F3);
      end
      if (imem_req && imem_addr == 32'h0000_0000) seen0 = 1'b1;
      tick();
    end
    chk("t5_seen_wrap_pc", {31'b0, seen_wrap}, 32'd1);
    chk("t5_seen_addr0",   {31'b0, seen0},     32'd1);

    // Reset mid-stream with a non-empty buffer
    Stall = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("t6_nonempty", {31'b0, ValidF}, 32'd1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_req_in_reset", {31'b0, imem_req}, 32'd0);
    tick();
    rst_n = 1'b1;
    Stall = 1'b0;
    @(negedge clk);
    chk("t6_valid", {31'b0, ValidF}, 32'd0);
    chk("t6_instr", InstrF,  32'h0000_0013);
    chk("t6_pc",    PCF,     32'h0000_0000);
    chk("t6_inc",   inc_PCF, 32'h0000_0000);
    chk("t6_req",   {31'b0, imem_req}, 32'd1);
    chk("t6_addr",  imem_addr, 32'hBFC0_0000);

    // Mixed pattern: ready gaps, stalls, back-to-back redirects, latency change
    mem_lat = 2;
    for (int i = 0; i < 60; i++) begin
      tick();
      imem_ready = (i % 3) != 0;
      Stall      = (i % 5) == 2;
      PCSrcE     = (i == 25) || (i == 26);
      PCTargetE  = (i == 25) ? 32'h0000_1002 : 32'h0000_2000;
      mem_lat    = (i < 40) ? 2 : 1;
    end
    tick();
    imem_ready = 1'b1;
    Stall = 1'b0;
    PCSrcE = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
